// File: rtl/if_stage_pkg.sv
// Shared fetch-stage configuration: widths, icache geometry and FSM encodings.
package if_stage_pkg;
   localparam int AddrLen    = 32;
   localparam int InstLen    = 32;
   localparam int ICacheIdxW = 6;
   localparam logic [InstLen-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      IF_IDLE    = 2'd0,
      IF_MISS    = 2'd1,
      IF_DISCARD = 2'd2
   } if_state_e;
endpackage

// File: rtl/if_stage_icache_dm.sv
// Direct-mapped one-word-per-line icache: combinational lookup, synchronous fill.
// Only the valid bits are reset; tag/data contents are don't-care until filled.
module icache_dm
   import if_stage_pkg::*;
#(
   parameter int ADDR_W = AddrLen,
   parameter int INST_W = InstLen,
   parameter int IDX_W  = ICacheIdxW
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [IDX_W-1:0]          rd_idx,
   input  logic [ADDR_W-IDX_W-3:0]   rd_tag,
   output logic                      rd_hit,
   output logic [INST_W-1:0]         rd_data,
   input  logic                      fill_en,
   input  logic [IDX_W-1:0]          fill_idx,
   input  logic [ADDR_W-IDX_W-3:0]   fill_tag,
   input  logic [INST_W-1:0]         fill_data
);
   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0]        valid_q, valid_d;
   logic [ADDR_W-IDX_W-3:0] tag_q  [LINES];
   logic [INST_W-1:0]       data_q [LINES];

   always_comb begin
      valid_d = valid_q;
      if (fill_en) valid_d[fill_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) valid_q <= '0;
      else      valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= fill_data;
      end
   end

   assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_data = data_q[rd_idx];
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: 1-cycle hit latency through the icache, single-word refill on miss.
// if_stall_o holds the PC register while busy or stalled; flush always releases it.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int ADDR_W = AddrLen,
   parameter int INST_W = InstLen,
   parameter int IDX_W  = ICacheIdxW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              flush_i,
   input  logic              stall_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [INST_W-1:0] mem_data_i,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [INST_W-1:0] if_inst_o,
   output logic              if_valid_o,
   output logic              if_stall_o
);
   if_state_e         state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] miss_pc_q, miss_pc_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              valid_q, valid_d;
   logic              hit, fill_en, stall;
   logic [INST_W-1:0] line_data;
   logic              unused_bits;

   assign unused_bits = ^pc_i[1:0];

   icache_dm #(.ADDR_W(ADDR_W), .INST_W(INST_W), .IDX_W(IDX_W)) u_icache (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (pc_i[IDX_W+1:2]),
      .rd_tag    (pc_i[ADDR_W-1:IDX_W+2]),
      .rd_hit    (hit),
      .rd_data   (line_data),
      .fill_en   (fill_en && rdy),
      .fill_idx  (addr_q[IDX_W+1:2]),
      .fill_tag  (addr_q[ADDR_W-1:IDX_W+2]),
      .fill_data (mem_data_i)
   );

   // A cycle that delivers nothing while ID is not stalled leaves a bubble (valid=0).
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      addr_d    = addr_q;
      miss_pc_d = miss_pc_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      valid_d   = valid_q;
      fill_en   = 1'b0;
      stall     = 1'b1;
      case (state_q)
         IF_IDLE: begin
            if (flush_i) begin
               stall   = 1'b0;
               valid_d = 1'b0;
            end else if (stall_i) begin
               stall = 1'b1;
            end else if (hit) begin
               stall   = 1'b0;
               pc_d    = pc_i;
               inst_d  = line_data;
               valid_d = 1'b1;
            end else begin
               valid_d   = 1'b0;
               miss_pc_d = pc_i;
               req_d     = 1'b1;
               addr_d    = pc_i;
               state_d   = IF_MISS;
            end
         end
         IF_MISS: begin
            if (mem_ack_i) begin
               fill_en = 1'b1;
               req_d   = 1'b0;
               state_d = IF_IDLE;
            end else if (flush_i) begin
               state_d = IF_DISCARD;
            end
            if (flush_i) begin
               stall   = 1'b0;
               valid_d = 1'b0;
            end else if (mem_ack_i && !stall_i) begin
               stall   = 1'b0;
               pc_d    = miss_pc_q;
               inst_d  = mem_data_i;
               valid_d = 1'b1;
            end else if (!stall_i) begin
               valid_d = 1'b0;
            end
         end
         IF_DISCARD: begin
            if (mem_ack_i) begin
               fill_en = 1'b1;
               req_d   = 1'b0;
               state_d = IF_IDLE;
            end
            if (flush_i) begin
               stall   = 1'b0;
               valid_d = 1'b0;
            end else if (!stall_i) begin
               valid_d = 1'b0;
            end
         end
         default: state_d = IF_IDLE;
      endcase
      if (!rst) stall = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IF_IDLE;
         req_q     <= 1'b0;
         addr_q    <= '0;
         miss_pc_q <= '0;
         pc_q      <= '0;
         inst_q    <= ZERO_WORD[INST_W-1:0];
         valid_q   <= 1'b0;
      end else if (rdy) begin
         state_q   <= state_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         miss_pc_q <= miss_pc_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         valid_q   <= valid_d;
      end
   end

   assign mem_req_o  = req_q;
   assign mem_addr_o = addr_q;
   assign if_pc_o    = pc_q;
   assign if_inst_o  = inst_q;
   assign if_valid_o = valid_q;
   assign if_stall_o = stall;
endmodule

// File: tb/tb_if_stage.sv
// Directed scenarios plus a randomized run checked against a transaction-level
// model (PC-register handshake, memory controller and an abstract cache map).
module tb_if_stage;
   logic        clk, rst, rdy, flush_i, stall_i, mem_ack_i;
   logic [31:0] pc_i, mem_data_i;
   logic        mem_req_o, if_valid_o, if_stall_o;
   logic [31:0] mem_addr_o, if_pc_o, if_inst_o;
   int          n_cmp, n_bad;

   if_stage dut (
      .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i), .flush_i(flush_i), .stall_i(stall_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
      .mem_data_i(mem_data_i), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
      .if_valid_o(if_valid_o), .if_stall_o(if_stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      flush_i = 1'b0; stall_i = 1'b0; mem_ack_i = 1'b0; rdy = 1'b1; mem_data_i = '0;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      idle_inputs();
      tick(); tick();
      rst = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0; pc_i = 32'h40; idle_inputs();
      tick(); tick();
      n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", if_valid_o); end
      n_cmp++; if (if_pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", if_pc_o); end
      n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
      n_cmp++; if (if_stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", if_stall_o); end
      rst = 1'b1; #1;
      n_cmp++; if (if_stall_o !== 1'b1) begin n_bad++; $display("FAIL reset_first_miss_stall: got %b want 1", if_stall_o); end
      tick();
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin n_bad++; $display("FAIL reset_first_miss_req: got req=%b addr=%h want req=1 addr=40", mem_req_o, mem_addr_o); end
      mem_ack_i = 1'b1; mem_data_i = 32'hDEAD0040;
      tick();
      mem_ack_i = 1'b0;
   endtask

   task automatic test_cold_miss_hit;
      pc_i = 32'h0; #1;
      n_cmp++; if (if_stall_o !== 1'b1) begin n_bad++; $display("FAIL cold_stall_issue: got %b want 1", if_stall_o); end
      tick();
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL cold_req: got req=%b addr=%h want req=1 addr=0", mem_req_o, mem_addr_o); end
      for (int i = 0; i < 2; i++) begin
         n_cmp++; if (if_stall_o !== 1'b1) begin n_bad++; $display("FAIL cold_stall_wait%0d: got %b want 1", i, if_stall_o); end
         tick();
      end
      mem_ack_i = 1'b1; mem_data_i = 32'h00000013; #1;
      n_cmp++; if (if_stall_o !== 1'b0) begin n_bad++; $display("FAIL cold_stall_ack: got %b want 0", if_stall_o); end
      tick();
      mem_ack_i = 1'b0;
      n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_inst_o !== 32'h13) begin n_bad++; $display("FAIL cold_deliver: got v=%b pc=%h inst=%h want v=1 pc=0 inst=13", if_valid_o, if_pc_o, if_inst_o); end
      pc_i = 32'h40; #1;
      n_cmp++; if (if_stall_o !== 1'b0) begin n_bad++; $display("FAIL hit40_stall: got %b want 0", if_stall_o); end
      tick();
      n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40 || if_inst_o !== 32'hDEAD0040) begin n_bad++; $display("FAIL hit40_deliver: got v=%b pc=%h inst=%h want v=1 pc=40 inst=dead0040", if_valid_o, if_pc_o, if_inst_o); end
      pc_i = 32'h0; #1;
      n_cmp++; if (if_stall_o !== 1'b0) begin n_bad++; $display("FAIL hit0_stall: got %b want 0", if_stall_o); end
      tick();
      n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_inst_o !== 32'h13 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL hit0_deliver: got v=%b pc=%h inst=%h req=%b want v=1 pc=0 inst=13 req=0", if_valid_o, if_pc_o, if_inst_o, mem_req_o); end
   endtask

   task automatic test_conflict;
      pc_i = 32'h100; #1;
      n_cmp++; if (if_stall_o !== 1'b1) begin n_bad++; $display("FAIL conflict_stall: got %b want 1", if_stall_o); end
      tick();
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin n_bad++; $display("FAIL conflict_req: got req=%b addr=%h want req=1 addr=100", mem_req_o, mem_addr_o); end
      mem_ack_i = 1'b1; mem_data_i = 32'h000100AA;
      tick();
      mem_ack_i = 1'b0;
      n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 || if_inst_o !== 32'h000100AA) begin n_bad++; $display("FAIL conflict_deliver: got v=%b pc=%h inst=%h want v=1 pc=100 inst=000100aa", if_valid_o, if_pc_o, if_inst_o); end
      pc_i = 32'h0; #1;
      n_cmp++; if (if_stall_o !== 1'b1) begin n_bad++; $display("FAIL conflict_refetch_stall: got %b want 1", if_stall_o); end
      tick();
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL conflict_refetch_req: got req=%b addr=%h want req=1 addr=0", mem_req_o, mem_addr_o); end
      mem_ack_i = 1'b1; mem_data_i = 32'h00000013;
      tick();
      mem_ack_i = 1'b0;
   endtask

   task automatic test_flush_miss;
      pc_i = 32'h8;
      tick();
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8) begin n_bad++; $display("FAIL flush_req: got req=%b addr=%h want req=1 addr=8", mem_req_o, mem_addr_o); end
      tick();
      flush_i = 1'b1; #1;
      n_cmp++; if (if_stall_o !== 1'b0) begin n_bad++; $display("FAIL flush_stall_flushcyc: got %b want 0", if_stall_o); end
      tick();
      flush_i = 1'b0; pc_i = 32'h40; #1;
      n_cmp++; if (if_stall_o !== 1'b1 || if_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_discard1: got stall=%b v=%b want stall=1 v=0", if_stall_o, if_valid_o); end
      tick();
      mem_ack_i = 1'b1; mem_data_i = 32'h00000088; #1;
      n_cmp++; if (if_stall_o !== 1'b1) begin n_bad++; $display("FAIL flush_stall_ackcyc: got %b want 1", if_stall_o); end
      tick();
      mem_ack_i = 1'b0; #1;
      n_cmp++; if (if_valid_o !== 1'b0 || if_stall_o !== 1'b0) begin n_bad++; $display("FAIL flush_after_ack: got v=%b stall=%b want v=0 stall=0", if_valid_o, if_stall_o); end
      tick();
      n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40) begin n_bad++; $display("FAIL flush_npc_deliver: got v=%b pc=%h want v=1 pc=40", if_valid_o, if_pc_o); end
      pc_i = 32'h8; #1;
      n_cmp++; if (if_stall_o !== 1'b0) begin n_bad++; $display("FAIL flush_line8_hit: got stall=%b want 0", if_stall_o); end
      tick();
      n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8 || if_inst_o !== 32'h88 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL flush_line8_deliver: got v=%b pc=%h inst=%h req=%b want v=1 pc=8 inst=88 req=0", if_valid_o, if_pc_o, if_inst_o, mem_req_o); end
   endtask

   task automatic test_stall;
      pc_i = 32'h4;
      tick();
      mem_ack_i = 1'b1; mem_data_i = 32'h00000044;
      tick();
      mem_ack_i = 1'b0;
      pc_i = 32'h8; stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (if_stall_o !== 1'b1) begin n_bad++; $display("FAIL stall_out%0d: got %b want 1", i, if_stall_o); end
         tick();
         n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h4 || if_inst_o !== 32'h44) begin n_bad++; $display("FAIL stall_hold%0d: got v=%b pc=%h inst=%h want v=1 pc=4 inst=44", i, if_valid_o, if_pc_o, if_inst_o); end
      end
      stall_i = 1'b0; #1;
      n_cmp++; if (if_stall_o !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", if_stall_o); end
      tick();
      n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8 || if_inst_o !== 32'h88) begin n_bad++; $display("FAIL stall_next: got v=%b pc=%h inst=%h want v=1 pc=8 inst=88", if_valid_o, if_pc_o, if_inst_o); end
   endtask

   task automatic test_rdy_reset;
      pc_i = 32'hC;
      tick();
      rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hC || if_valid_o !== 1'b0 || if_pc_o !== 32'h8) begin n_bad++; $display("FAIL rdy_freeze%0d: got req=%b addr=%h v=%b pc=%h want req=1 addr=c v=0 pc=8", i, mem_req_o, mem_addr_o, if_valid_o, if_pc_o); end
      end
      rdy = 1'b1;
      tick();
      rst = 1'b0; #1;
      n_cmp++; if (mem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin n_bad++; $display("FAIL midmiss_reset: got req=%b v=%b want req=0 v=0", mem_req_o, if_valid_o); end
      tick();
      rst = 1'b1; pc_i = 32'h0; #1;
      n_cmp++; if (if_stall_o !== 1'b1) begin n_bad++; $display("FAIL reset_invalidate_stall: got %b want 1", if_stall_o); end
      tick();
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_invalidate_req: got req=%b addr=%h want req=1 addr=0", mem_req_o, mem_addr_o); end
      mem_ack_i = 1'b1; mem_data_i = 32'h13;
      tick();
      mem_ack_i = 1'b0;
   endtask

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] t, x;
      t = $urandom_range(0, 2);
      x = $urandom_range(0, 7);
      return (t << 8) | (x << 2);
   endfunction

   task automatic test_random;
      bit          m_vld [64];
      logic [23:0] m_tag [64];
      bit          outstanding, discard, ack, es, hit;
      int          delay;
      logic [31:0] req_addr, pc_cur, exp_pc, exp_inst, exp_addr;
      logic        exp_valid, exp_req;
      do_reset();
      for (int k = 0; k < 64; k++) m_vld[k] = 1'b0;
      outstanding = 0; discard = 0; delay = 0; req_addr = '0;
      exp_pc = '0; exp_inst = '0; exp_valid = 1'b0; exp_req = 1'b0; exp_addr = '0;
      pc_cur = rand_pc();
      for (int cyc = 0; cyc < 600; cyc++) begin
         rdy     = ($urandom_range(0, 19) != 0);
         stall_i = ($urandom_range(0, 5) == 0);
         flush_i = rdy && ($urandom_range(0, 9) == 0);
         ack     = rdy && outstanding && (delay == 0);
         mem_ack_i  = ack;
         mem_data_i = ack ? memfn(req_addr) : $urandom;
         pc_i = pc_cur;
         #1;
         hit = m_vld[pc_cur[7:2]] && (m_tag[pc_cur[7:2]] == pc_cur[31:8]);
         if (flush_i)          es = 1'b0;
         else if (outstanding) es = !(!discard && ack && !stall_i);
         else if (stall_i)     es = 1'b1;
         else                  es = !hit;
         n_cmp++; if (if_stall_o !== es) begin n_bad++; $display("FAIL rnd_stall cyc%0d pc=%h: got %b want %b", cyc, pc_cur, if_stall_o, es); end
         if (rdy) begin
            if (flush_i) exp_valid = 1'b0;
            else if (!es) begin exp_pc = pc_cur; exp_inst = memfn(pc_cur); exp_valid = 1'b1; end
            else if (!stall_i) exp_valid = 1'b0;
            if (outstanding) begin
               if (ack) begin
                  m_vld[req_addr[7:2]] = 1'b1;
                  m_tag[req_addr[7:2]] = req_addr[31:8];
                  outstanding = 0; exp_req = 1'b0;
               end else begin
                  if (flush_i) discard = 1;
                  if (delay > 0) delay--;
               end
            end else if (!flush_i && !stall_i && !hit) begin
               outstanding = 1; discard = 0; req_addr = pc_cur;
               exp_req = 1'b1; exp_addr = pc_cur; delay = $urandom_range(0, 3);
            end
            if (flush_i || !es) pc_cur = rand_pc();
         end
         tick();
         mem_ack_i = 1'b0;
         n_cmp++; if (if_valid_o !== exp_valid) begin n_bad++; $display("FAIL rnd_valid cyc%0d: got %b want %b", cyc, if_valid_o, exp_valid); end
         n_cmp++; if (if_pc_o !== exp_pc || if_inst_o !== exp_inst) begin n_bad++; $display("FAIL rnd_data cyc%0d: got pc=%h inst=%h want pc=%h inst=%h", cyc, if_pc_o, if_inst_o, exp_pc, exp_inst); end
         n_cmp++; if (mem_req_o !== exp_req || (exp_req && mem_addr_o !== exp_addr)) begin n_bad++; $display("FAIL rnd_req cyc%0d: got req=%b addr=%h want req=%b addr=%h", cyc, mem_req_o, mem_addr_o, exp_req, exp_addr); end
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      pc_i = '0;
      test_reset();
      test_cold_miss_hit();
      test_conflict();
      test_flush_miss();
      test_stall();
      test_rdy_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
